// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder: sums WIDTH-bit operands CHUNK bits per clock, LSB chunk first.
// Define ADDER_SUB_EN to add the sub port (a - b as a + ~b + 1).
module seq_chunk_adder #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned N  = WIDTH / CHUNK;
  localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] KLast = KW'(N - 1);

  if ((WIDTH % CHUNK) != 0 || CHUNK == 0) begin : g_bad_params
    $error("seq_chunk_adder: WIDTH must be a non-zero multiple of CHUNK");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           r_state;
  state_e           w_state_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [KW-1:0]    r_k;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;

  logic             w_sub;
  logic             w_capture;
  logic             w_last;
  logic [CHUNK-1:0] w_a_c;
  logic [CHUNK-1:0] w_b_c;
  logic [CHUNK:0]   w_chunk_full;
  logic [CHUNK-1:0] w_chunk_sum;
  logic             w_carry_next;
  logic             w_cin_msb;
  logic [WIDTH-1:0] w_acc_next;

`ifdef ADDER_SUB_EN
  assign w_sub = sub;
`else
  assign w_sub = 1'b0;
`endif

  assign w_capture = start && (r_state != StRun);
  assign w_last    = (r_k == KLast);

  // Operands shift right each RUN cycle, so the current chunk always sits at the bottom.
  assign w_a_c        = r_a[CHUNK-1:0];
  assign w_b_c        = r_b[CHUNK-1:0];
  assign w_chunk_full = {1'b0, w_a_c} + {1'b0, w_b_c} + {{CHUNK{1'b0}}, r_carry};
  assign w_chunk_sum  = w_chunk_full[CHUNK-1:0];
  assign w_carry_next = w_chunk_full[CHUNK];
  // Carry into the chunk MSB recovered from s = a ^ b ^ c; on the last chunk this is bit WIDTH-1.
  assign w_cin_msb    = w_a_c[CHUNK-1] ^ w_b_c[CHUNK-1] ^ w_chunk_sum[CHUNK-1];
  assign w_acc_next   = (r_acc >> CHUNK) | (WIDTH'(w_chunk_sum) << (WIDTH - CHUNK));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (start) w_state_next = StRun;
      StRun:   if (w_last) w_state_next = StDone;
      StDone:  w_state_next = start ? StRun : StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    busy = (r_state == StRun);
    done = (r_state == StDone);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_k     <= '0;
      r_acc   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
    end else if (w_capture) begin
      r_a     <= a;
      r_b     <= w_sub ? ~b : b;
      r_carry <= w_sub ? 1'b1 : cin;
      r_k     <= '0;
      r_acc   <= '0;
    end else if (r_state == StRun) begin
      r_a     <= r_a >> CHUNK;
      r_b     <= r_b >> CHUNK;
      r_carry <= w_carry_next;
      r_k     <= r_k + KW'(1);
      r_acc   <= w_acc_next;
      if (w_last) begin
        r_sum  <= w_acc_next;
        r_cout <= w_carry_next;
        r_ovf  <= w_cin_msb ^ w_carry_next;
        r_zero <= (w_acc_next == '0);
      end
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;
  assign zero = r_zero;

endmodule
